// File: rtl/tgmux_bbm_n_pkg.sv
// Shared types and helpers for the break-before-make transmission-gate mux.
// The analog node values are signed fixed-point samples.
package tgmux_bbm_n_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BREAK = 2'd1,
      CONN  = 2'd2
   } state_t;

   localparam int XW = 16;
   typedef logic signed [XW-1:0] xreal_t;

   function automatic logic [31:0] onehot(input int unsigned idx);
      return 32'd1 << idx;
   endfunction

   // Wider devices mean a smaller RC time constant, so the output moves a larger fraction per cycle.
   function automatic int rc_shift(input int wp, input int wn);
      if (wp + wn >= 48) return 1;
      else if (wp + wn >= 24) return 2;
      else return 3;
   endfunction

endpackage

// File: rtl/tgmux_bbm_n_if.sv
// Select handshake, enable/status outputs and analog nodes of the mux.
interface tgmux_bbm_n_if #(parameter int N = 4);
   import tgmux_bbm_n_pkg::*;
   localparam int SELW = $clog2(N);

   logic [SELW-1:0] sel;
   logic            sel_vld;
   logic            sel_rdy;
   logic [N-1:0]    en;
   logic [SELW-1:0] act;
   logic            conn;
   logic            err;
   xreal_t          d [N];
   xreal_t          y;
   xreal_t          vdd;

   modport master (output sel, sel_vld, d, vdd,
                   input  sel_rdy, en, act, conn, err, y);
   modport slave  (input  sel, sel_vld, d, vdd,
                   output sel_rdy, en, act, conn, err, y);
endinterface

// File: rtl/tgmux_bbm_n_tg.sv
// One transmission gate with its enable inverter, as a first-order RC step toward the source.
module tgmux_bbm_n_tg
   import tgmux_bbm_n_pkg::*;
#(
   parameter int WP = 20,
   parameter int WN = 10
) (
   input  xreal_t               s,
   input  xreal_t               y,
   input  logic                 ckn,
   input  xreal_t               vdd,
   output logic signed [XW:0]   step
);
   localparam int SH = rc_shift(WP, WN);

   logic               ckp;
   logic               conducts;
   logic signed [XW:0] diff;
   logic signed [XW:0] shifted;

   assign ckp      = ~ckn;
   assign conducts = ckn & ~ckp & (vdd > xreal_t'(0));
   assign diff     = {s[XW-1], s} - {y[XW-1], y};
   assign shifted  = diff >>> SH;
   assign step     = conducts ? shifted : '0;

endmodule

// File: rtl/tgmux_bbm_n.sv
// N-input TG analog mux with registered, break-before-make channel switching.
//  state | meaning
//  IDLE  | all switches open, ready for a request
//  BREAK | all switches open, dead-time counter running
//  CONN  | en = onehot(act), ready for a request
module tgmux_bbm_n
   import tgmux_bbm_n_pkg::*;
#(
   parameter int N    = 4,
   parameter int WP   = 20,
   parameter int WN   = 10,
   parameter int DEAD = 2
) (
   input logic            clk,
   input logic            rst,
   tgmux_bbm_n_if.slave   bus
);
   localparam int SELW = $clog2(N);
   localparam int CW   = $clog2(DEAD + 1);

   if (N < 2 || DEAD < 1) begin : g_param_chk
      $error("tgmux_bbm_n: N must be >= 2 and DEAD >= 1");
   end

   state_t             state_q, state_n;
   logic [CW-1:0]      cnt_q, cnt_n;
   logic [SELW-1:0]    tgt_q, tgt_n, act_q, act_n;
   logic               disc_q, disc_n;
   logic [N-1:0]       en_q, en_n;
   logic               conn_q, conn_n, err_q, err_n;
   logic               accept, sel_ok;
   xreal_t             y_q;
   logic signed [XW:0] acc;
   logic signed [XW:0] step [N];

   assign bus.sel_rdy = (state_q != BREAK);
   assign accept      = bus.sel_vld & bus.sel_rdy;
   assign sel_ok      = 32'(bus.sel) < N;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      tgt_n   = tgt_q;
      disc_n  = disc_q;
      act_n   = act_q;
      en_n    = en_q;
      conn_n  = conn_q;
      err_n   = 1'b0;
      case (state_q)
         IDLE, CONN: begin
            // Re-requesting the connected channel must not open the switch.
            if (accept && !(state_q == CONN && sel_ok && bus.sel == act_q)) begin
               state_n = BREAK;
               cnt_n   = CW'(DEAD - 1);
               tgt_n   = bus.sel;
               disc_n  = !sel_ok;
               err_n   = !sel_ok;
               en_n    = '0;
               conn_n  = 1'b0;
            end
         end
         BREAK: begin
            if (cnt_q == '0) begin
               if (disc_q) begin
                  state_n = IDLE;
               end else begin
                  state_n = CONN;
                  act_n   = tgt_q;
                  en_n    = N'(onehot(32'(tgt_q)));
                  conn_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            en_n    = '0;
            conn_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         disc_q  <= 1'b0;
         act_q   <= '0;
         en_q    <= '0;
         conn_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         tgt_q   <= tgt_n;
         disc_q  <= disc_n;
         act_q   <= act_n;
         en_q    <= en_n;
         conn_q  <= conn_n;
         err_q   <= err_n;
      end
   end

   assign bus.en   = en_q;
   assign bus.act  = act_q;
   assign bus.conn = conn_q;
   assign bus.err  = err_q;

   for (genvar i = 0; i < N; i++) begin : g_tg
      tgmux_bbm_n_tg #(.WP(WP), .WN(WN)) u_tg (
         .s    (bus.d[i]),
         .y    (y_q),
         .ckn  (en_q[i]),
         .vdd  (bus.vdd),
         .step (step[i])
      );
   end

   // With every switch open no step is applied, so the output node holds its charge.
   always_comb begin
      acc = {y_q[XW-1], y_q};
      for (int i = 0; i < N; i++) acc = acc + step[i];
   end

   always_ff @(posedge clk) begin
      if (rst) y_q <= '0;
      else     y_q <= xreal_t'(acc);
   end

   assign bus.y = y_q;

   a_onehot: assert property (@(posedge clk) $onehot0(en_q))
      else $error("tgmux_bbm_n: more than one enable active");

   a_bbm: assert property (@(posedge clk) disable iff (rst)
      ((en_q != '0) && ($past(en_q) != '0)) |-> (en_q == $past(en_q)))
      else $error("tgmux_bbm_n: channel switched without a break interval");

endmodule

// File: tb/tb_tgmux_bbm_n.sv
// Directed bench: stimulus pushes hand-computed expectations, per-DUT monitors pop and compare.
module tb_tgmux_bbm_n;
   import tgmux_bbm_n_pkg::*;

   typedef struct {
      bit         dut3;
      bit         rst;
      bit         vld;
      int         sel;
      logic [3:0] en;
      bit         conn;
      int         act;
      bit         err;
      bit         rdy;
      bit         chk_y;
      int         y;
      string      name;
   } step_t;

   logic clk = 1'b0;
   logic rst4, rst3;
   int   checks = 0;
   int   failures = 0;
   step_t steps [$];
   step_t q4 [$];
   step_t q3 [$];

   always #5 clk = ~clk;

   tgmux_bbm_n_if #(.N(4)) bus4 ();
   tgmux_bbm_n_if #(.N(3)) bus3 ();

   tgmux_bbm_n #(.N(4), .WP(20), .WN(10), .DEAD(2)) u_dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4)
   );

   tgmux_bbm_n #(.N(3), .WP(20), .WN(10), .DEAD(2)) u_dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (bus3)
   );

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic chk_y(input string nm, input int got, input int want);
      int diff;
      diff = got - want;
      checks++;
      if (diff > 4 || diff < -4) begin
         failures++;
         $display("FAIL %s y got=%0d want=%0d (+/-4)", nm, got, want);
      end
   endtask

   function automatic void add(bit d3, bit r, bit v, int s, logic [3:0] en, bit c, int a,
                               bit e, bit rdy, string nm, bit cy = 1'b0, int y = 0);
      step_t st;
      st.dut3 = d3; st.rst = r; st.vld = v; st.sel = s; st.en = en; st.conn = c;
      st.act = a; st.err = e; st.rdy = rdy; st.chk_y = cy; st.y = y; st.name = nm;
      steps.push_back(st);
   endfunction

   always @(negedge clk) begin : mon4
      step_t e;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk({e.name, ".en"},   int'(bus4.en),      int'(e.en));
         chk({e.name, ".conn"}, int'(bus4.conn),    int'(e.conn));
         chk({e.name, ".err"},  int'(bus4.err),     int'(e.err));
         chk({e.name, ".rdy"},  int'(bus4.sel_rdy), int'(e.rdy));
         if (e.conn) chk({e.name, ".act"}, int'(bus4.act), e.act);
         if (e.chk_y) chk_y(e.name, int'(bus4.y), e.y);
      end
   end

   always @(negedge clk) begin : mon3
      step_t e;
      if (q3.size() > 0) begin
         e = q3.pop_front();
         chk({e.name, ".en"},   int'(bus3.en),      int'(e.en[2:0]));
         chk({e.name, ".conn"}, int'(bus3.conn),    int'(e.conn));
         chk({e.name, ".err"},  int'(bus3.err),     int'(e.err));
         chk({e.name, ".rdy"},  int'(bus3.sel_rdy), int'(e.rdy));
         if (e.conn) chk({e.name, ".act"}, int'(bus3.act), e.act);
      end
   end

   initial begin
      // 4-channel DUT: d = 1000, -2000, 3000, 500
      add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, "rst_a");
      add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, "rst_b");
      add(0, 0, 1, 2, 4'b0000, 0, 0, 0, 0, "t1_acc");
      add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t1_brk");
      add(0, 0, 0, 0, 4'b0100, 1, 2, 0, 1, "t1_conn");
      add(0, 0, 1, 2, 4'b0100, 1, 2, 0, 1, "t2_same0");
      add(0, 0, 1, 2, 4'b0100, 1, 2, 0, 1, "t2_same1");
      add(0, 0, 1, 2, 4'b0100, 1, 2, 0, 1, "t2_same2");
      add(0, 0, 0, 0, 4'b0100, 1, 2, 0, 1, "t2_hold");
      add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, "t3_brk0");
      add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t3_brk1");
      add(0, 0, 0, 0, 4'b0001, 1, 0, 0, 1, "t3_conn");
      for (int i = 0; i < 30; i++) add(0, 0, 0, 0, 4'b0001, 1, 0, 0, 1, "t3_settle", i == 29, 1000);
      add(0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, "t4_brk0");
      add(0, 0, 1, 3, 4'b0000, 0, 0, 0, 0, "t4_ign0");
      add(0, 0, 1, 3, 4'b0010, 1, 1, 0, 1, "t4_ign1");
      add(0, 0, 1, 3, 4'b0000, 0, 0, 0, 0, "t4_acc");
      add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t4_brk");
      add(0, 0, 0, 0, 4'b1000, 1, 3, 0, 1, "t4_conn");
      for (int i = 0; i < 30; i++) add(0, 0, 0, 0, 4'b1000, 1, 3, 0, 1, "t4_settle", i == 29, 500);
      add(0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, "t6_brk");
      add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, "t6_rst");
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, "t6_idle");
      // 3-channel DUT: out-of-range select 3
      add(1, 1, 0, 0, 4'b0000, 0, 0, 0, 1, "t5_rst");
      add(1, 0, 1, 3, 4'b0000, 0, 0, 1, 0, "t5_err");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t5_brk");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 1, "t5_idle");
      add(1, 0, 1, 1, 4'b0000, 0, 0, 0, 0, "t5_acc");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t5_brk1");
      add(1, 0, 0, 0, 4'b0010, 1, 1, 0, 1, "t5_conn");
      add(1, 0, 1, 3, 4'b0000, 0, 0, 1, 0, "t5_err2");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, "t5_brk2");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 1, "t5_idle2");
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 1, "t5_idle3");

      bus4.d[0] = 16'sd1000;  bus4.d[1] = -16'sd2000;
      bus4.d[2] = 16'sd3000;  bus4.d[3] = 16'sd500;
      bus3.d[0] = 16'sd700;   bus3.d[1] = -16'sd700;  bus3.d[2] = 16'sd1500;
      bus4.vdd = 16'sd1000;   bus3.vdd = 16'sd1000;
      bus4.sel = '0; bus4.sel_vld = 1'b0;
      bus3.sel = '0; bus3.sel_vld = 1'b0;
      rst4 = 1'b1; rst3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      foreach (steps[i]) begin
         if (steps[i].dut3) begin
            rst3 = steps[i].rst; bus3.sel_vld = steps[i].vld; bus3.sel = 2'(steps[i].sel);
            rst4 = 1'b0;         bus4.sel_vld = 1'b0;
         end else begin
            rst4 = steps[i].rst; bus4.sel_vld = steps[i].vld; bus4.sel = 2'(steps[i].sel);
            rst3 = 1'b0;         bus3.sel_vld = 1'b0;
         end
         @(posedge clk);
         #1;
         if (steps[i].dut3) q3.push_back(steps[i]);
         else               q4.push_back(steps[i]);
      end
      bus4.sel_vld = 1'b0;
      bus3.sel_vld = 1'b0;

      for (int i = 0; i < 5 && (q3.size() > 0 || q4.size() > 0); i++) @(negedge clk);
      #1;
      if (q3.size() > 0 || q4.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d want=0", q3.size() + q4.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
